data_island_packet_stream_serializer: RTL
=========================================

# data_island_packet_stream_serializer

Serializes one or more HDMI data island packets, back-to-back, onto the three TERC4 channels for a single data island period. It sits between the packet arbiter (upstream, valid/ready) and the TERC4 encoders (downstream). It generalises single-packet serialization to islands of 1..MAX_PACKETS packets. Header and subpacket BCH parity are generated internally, and a null packet is inserted whenever upstream has nothing ready at a packet boundary.

## Interface
- MAX_PACKETS, 18: maximum packets per island (1..18)
- CNT_W, $clog2(MAX_PACKETS+1): width of packetCount
- clock  in  1  sole clock, TMDS character rate
- reset  in  1  synchronous, active-high
- islandStart  in  1  one-cycle pulse: island begins next cycle
- packetCount  in  CNT_W  packets in this island, sampled with islandStart
- hsync, vsync  in  1 each  sync levels to embed in channel 0
- packetValid  in  1  upstream packet available
- packetReady  out  1  packet accepted this cycle when packetValid also high
- header  in  24  HB0..HB2, HB0 in bits [7:0]
- subpacket0..subpacket3  in  56 each  SBn0..SBn6, byte 0 in bits [7:0]
- terc4channel0/1/2  out  4 each  TERC4 nibbles
- islandActive  out  1  nibbles are island data
- islandDone  out  1  high on last clock of last packet

## Operation
- Sole clock port is `clock`; `reset` is synchronous and active-high.
- States: IDLE, SEND.
- IDLE → SEND on islandStart with packetCount ≠ 0. Latch min(packetCount, MAX_PACKETS) as remaining. packetCount = 0 is ignored.
- Packet fetch points:
  - the islandStart cycle;
  - slot 31 of each packet while remaining > 1.
- At a fetch point, packetReady = 1 (combinational). If packetValid = 1, latch header and subpackets. Otherwise latch a null packet (all zero) and do not assert a transfer.
- packetReady is 0 at all other times.
- Packet slot s (0..31):
  - channel0[2] = header bit s for s < 24, else header parity bit s−24.
  - channel1[n] = subpacket n bit 2s for s < 28, else parity bit 2(s−28).
  - channel2[n] = subpacket n bit 2s+1 for s < 28, else parity bit 2(s−28)+1.
- Parity: HDMI BCH(32,24) for the header and BCH(64,56) for each subpacket, generator x⁸+x⁷+x⁶+1, LSB-first. The LFSR clears at slot 0 of every packet.
- channel0[0] = hsync and channel0[1] = vsync, always.
- channel0[3] = 0 only on slot 0 of packet 0. It is 1 on every other island clock, including slot 0 of later packets.
- After slot 31 of the last packet: SEND → IDLE.
- islandStart during SEND is ignored.
- In IDLE: terc4channel1/2 = 0; channel0[3:2] = 0; islandActive = 0.

## Timing
- All outputs are registered.
- Latency: islandStart at cycle T → slot 0 of packet 0 on outputs at T+1. Packet k, slot s appears at T+1+32k+s.
- hsync/vsync have the same 1-cycle latency.
- islandActive is high for exactly 32·count cycles.
- islandDone is high at T+32·count.
- islandStart is accepted again in the cycle islandDone is high, so the next island is back-to-back.
- Reset values: all terc4 bits 0, islandActive 0, islandDone 0, packetReady 0, state IDLE, LFSRs 0.
- Reset mid-island: outputs return to reset values next cycle. The partial packet is abandoned and no further packetReady is issued.
- reset and islandStart in the same cycle: reset wins.

## Structure
- Shared package (hdmi_data_island_pkg):
  - PACKET_CLOCKS = 32
  - HEADER_DATA_CLOCKS = 24
  - SUBPACKET_DATA_CLOCKS = 28
  - BCH_POLY
  - NULL_PACKET header/subpacket constants
  - state enum
- One sub-module: bch_lane_parity_generator, parameterised BITS_PER_CLOCK (1 or 2). Five instances: one with BITS_PER_CLOCK = 1 for the header, four with BITS_PER_CLOCK = 2 for the subpackets.
- Top level holds: FSM, slot counter (5 bits), remaining counter (CNT_W), packet registers.

## Test plan
- islandStart, packetCount = 1, packetValid = 0 → 32 clocks of null packet:
  - channel1/2 = 0 and all parity 0;
  - channel0[3] = 0 only at T+1;
  - packetReady high at T only;
  - islandDone at T+32.
- packetCount = 3, three distinct valid packets, header 24'h0D0282 (AVI InfoFrame) → all 96 nibbles match the bench BCH/TERC4 model; packetReady at T, T+31, T+63.
- packetCount = 2, packetValid low at second fetch → packet 1 is null; second packet is not consumed (remains for next island).
- packetCount = 25 with MAX_PACKETS = 18 → exactly 576 active clocks, 18 packetReady pulses.
- Reset asserted at slot 10 of packet 1 → outputs 0 next cycle; no further packetReady; new islandStart works normally.
- islandStart during SEND, and packetCount = 0 in IDLE → both ignored; back-to-back island starting on the islandDone cycle has channel0[3] = 0 at its first clock.

Source files
------------

// File: rtl/data_island_packet_stream_serializer_pkg.sv
// Shared constants, state encoding and the BCH step used by the data island serializer.
package hdmi_data_island_pkg;
    localparam int PACKET_CLOCKS         = 32;
    localparam int HEADER_DATA_CLOCKS    = 24;
    localparam int SUBPACKET_DATA_CLOCKS = 28;

    // x^8+x^7+x^6+1 in LSB-first (right-shifting) form
    localparam logic [7:0]  BCH_POLY              = 8'h83;
    localparam logic [23:0] NULL_PACKET_HEADER    = 24'h000000;
    localparam logic [55:0] NULL_PACKET_SUBPACKET = 56'h0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } island_state_e;

    function automatic logic [7:0] bch_step(input logic [7:0] lfsr, input logic bit_in);
        bch_step = (lfsr >> 1) ^ (((lfsr[0] ^ bit_in) == 1'b1) ? BCH_POLY : 8'h00);
    endfunction
endpackage

// File: rtl/data_island_packet_stream_serializer_bch.sv
// BCH parity LFSR for one lane, absorbing BITS_PER_CLOCK data bits per clock LSB-first.
// clear_i restarts the code word on the same clock as its first data bits.
module bch_lane_parity_generator
    import hdmi_data_island_pkg::*;
#(
    parameter int BITS_PER_CLOCK = 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      clear_i,
    input  logic                      shift_i,
    input  logic [BITS_PER_CLOCK-1:0] bits_i,
    output logic [7:0]                parity_o
);
    logic [7:0] lfsr_q;
    logic [7:0] lfsr_d;

    always_comb begin
        lfsr_d = clear_i ? 8'h00 : lfsr_q;
        if (shift_i) begin
            for (int i = 0; i < BITS_PER_CLOCK; i++) begin
                lfsr_d = bch_step(lfsr_d, bits_i[i]);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            lfsr_q <= 8'h00;
        end else if (shift_i || clear_i) begin
            lfsr_q <= lfsr_d;
        end
    end

    assign parity_o = lfsr_q;
endmodule

// File: rtl/data_island_packet_stream_serializer.sv
// Serializes 1..MAX_PACKETS data island packets back-to-back onto three TERC4 channels.
// Slot 0 of packet 0 appears one clock after islandStart; upstream is pulled only at packet boundaries.
module data_island_packet_stream_serializer
    import hdmi_data_island_pkg::*;
#(
    parameter int MAX_PACKETS = 18,
    parameter int CNT_W       = $clog2(MAX_PACKETS + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             islandStart,
    input  logic [CNT_W-1:0] packetCount,
    input  logic             hsync,
    input  logic             vsync,
    input  logic             packetValid,
    output logic             packetReady,
    input  logic [23:0]      header,
    input  logic [55:0]      subpacket0,
    input  logic [55:0]      subpacket1,
    input  logic [55:0]      subpacket2,
    input  logic [55:0]      subpacket3,
    output logic [3:0]       terc4channel0,
    output logic [3:0]       terc4channel1,
    output logic [3:0]       terc4channel2,
    output logic             islandActive,
    output logic             islandDone
);
    localparam logic [CNT_W-1:0] MAX_CNT   = CNT_W'(MAX_PACKETS);
    localparam logic [CNT_W-1:0] ONE_CNT   = CNT_W'(1);
    localparam logic [4:0]       LAST_SLOT = 5'(PACKET_CLOCKS - 1);

    island_state_e    state_q;
    logic [4:0]       slot_q;
    logic [CNT_W-1:0] remaining_q;
    logic [23:0]      header_q;
    logic [55:0]      sub_q [4];

    logic        start, fetch, computing, last_of_island;
    logic [4:0]  cur_slot;
    logic        hdr_data_slot, sub_data_slot, bch_clear;
    logic [23:0] hdr_src;
    logic [55:0] sub_src [4];
    logic [1:0]  sub_bits [4];
    logic [7:0]  hdr_par;
    logic [7:0]  sub_par [4];
    logic        hdr_bit_d;
    logic [3:0]  ch1_d, ch2_d;
    logic [1:0]  lane;

    assign start          = (state_q == ST_IDLE) && islandStart && (packetCount != '0);
    assign fetch          = !reset && (start ||
                            ((state_q == ST_SEND) && (slot_q == LAST_SLOT) && (remaining_q > ONE_CNT)));
    assign packetReady    = fetch;
    assign computing      = start || (state_q == ST_SEND);
    assign cur_slot       = (state_q == ST_SEND) ? slot_q : 5'd0;
    assign last_of_island = (state_q == ST_SEND) && (slot_q == LAST_SLOT) && (remaining_q == ONE_CNT);
    assign hdr_data_slot  = cur_slot < 5'(HEADER_DATA_CLOCKS);
    assign sub_data_slot  = cur_slot < 5'(SUBPACKET_DATA_CLOCKS);
    assign bch_clear      = computing && (cur_slot == 5'd0);

    // A packet being fetched is serialized straight from the inputs on its first slot
    always_comb begin
        hdr_src = header_q;
        for (int n = 0; n < 4; n++) sub_src[n] = sub_q[n];
        if (fetch) begin
            if (packetValid) begin
                hdr_src    = header;
                sub_src[0] = subpacket0;
                sub_src[1] = subpacket1;
                sub_src[2] = subpacket2;
                sub_src[3] = subpacket3;
            end else begin
                hdr_src = NULL_PACKET_HEADER;
                for (int n = 0; n < 4; n++) sub_src[n] = NULL_PACKET_SUBPACKET;
            end
        end
    end

    always_comb begin
        lane      = 2'b00;
        ch1_d     = 4'h0;
        ch2_d     = 4'h0;
        hdr_bit_d = hdr_data_slot ? hdr_src[cur_slot] : hdr_par[cur_slot[2:0]];
        for (int n = 0; n < 4; n++) begin
            sub_bits[n] = {sub_src[n][{cur_slot, 1'b1}], sub_src[n][{cur_slot, 1'b0}]};
            lane = sub_data_slot ? sub_bits[n]
                                 : {sub_par[n][{cur_slot[1:0], 1'b1}], sub_par[n][{cur_slot[1:0], 1'b0}]};
            ch1_d[n] = lane[0];
            ch2_d[n] = lane[1];
        end
    end

    bch_lane_parity_generator #(.BITS_PER_CLOCK(1)) u_hdr_bch (
        .clock    (clock),
        .reset    (reset),
        .clear_i  (bch_clear),
        .shift_i  (computing && hdr_data_slot),
        .bits_i   (hdr_src[cur_slot]),
        .parity_o (hdr_par)
    );

    for (genvar g = 0; g < 4; g++) begin : g_sub_bch
        bch_lane_parity_generator #(.BITS_PER_CLOCK(2)) u_sub_bch (
            .clock    (clock),
            .reset    (reset),
            .clear_i  (bch_clear),
            .shift_i  (computing && sub_data_slot),
            .bits_i   (sub_bits[g]),
            .parity_o (sub_par[g])
        );
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            slot_q        <= 5'd0;
            remaining_q   <= '0;
            header_q      <= NULL_PACKET_HEADER;
            for (int n = 0; n < 4; n++) sub_q[n] <= NULL_PACKET_SUBPACKET;
            terc4channel0 <= 4'h0;
            terc4channel1 <= 4'h0;
            terc4channel2 <= 4'h0;
            islandActive  <= 1'b0;
            islandDone    <= 1'b0;
        end else begin
            // Preamble bit is low only for the very first island clock, which is computed in IDLE
            terc4channel0 <= {state_q == ST_SEND, computing && hdr_bit_d, vsync, hsync};
            terc4channel1 <= computing ? ch1_d : 4'h0;
            terc4channel2 <= computing ? ch2_d : 4'h0;
            islandActive  <= computing;
            islandDone    <= last_of_island;
            if (fetch) begin
                header_q <= hdr_src;
                for (int n = 0; n < 4; n++) sub_q[n] <= sub_src[n];
            end
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q     <= ST_SEND;
                        slot_q      <= 5'd1;
                        remaining_q <= (packetCount > MAX_CNT) ? MAX_CNT : packetCount;
                    end
                end
                ST_SEND: begin
                    slot_q <= slot_q + 5'd1;
                    if (slot_q == LAST_SLOT) begin
                        if (remaining_q == ONE_CNT) state_q <= ST_IDLE;
                        else remaining_q <= remaining_q - ONE_CNT;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end
endmodule
